// File: rtl/conv_sched_pkg.sv
// conv_sched_pkg: shared types and helpers for the convolution kernel scheduler.
//   state_t     : scheduler FSM state (IDLE, REPLAY)
//   WIN_ELEMS   : number of elements in a 3x3 window
//   pix_t/win_t : window element and window types at the default 8-bit data width
//   kidx_width  : width of the kernel index for a given kernel count (minimum 1)
package conv_sched_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        REPLAY = 1'b1
    } state_t;

    localparam int WIN_ELEMS      = 9;
    localparam int DEF_DATA_WIDTH = 8;

    typedef logic signed [DEF_DATA_WIDTH-1:0] pix_t;
    typedef pix_t [WIN_ELEMS-1:0]             win_t;

    function automatic int kidx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/conv_kernel_sched_if.sv
// conv_kernel_sched_if: window-in / replay-out bus of the kernel scheduler.
//   Handshake: a window transfers on a rising clk edge where valid_i and
//   ready_o are both high; the replay side (valid_o) has no backpressure.
//   Input side : win_i, valid_i, sop_i, eop_i, sof_i, eof_i, ready_o (back)
//   Output side: win_o, kidx_o, valid_o, sop_o, eop_o, sof_o, eof_o, busy_o, err_o
//   Modports   : master = window source / replay sink, slave = scheduler
interface conv_kernel_sched_if #(
    parameter int DATA_WIDTH = 8,
    parameter int KIDX_W     = 4
);
    import conv_sched_pkg::*;

    logic [WIN_ELEMS-1:0][DATA_WIDTH-1:0] win_i;
    logic                                 valid_i;
    logic                                 ready_o;
    logic                                 sop_i;
    logic                                 eop_i;
    logic                                 sof_i;
    logic                                 eof_i;

    logic [WIN_ELEMS-1:0][DATA_WIDTH-1:0] win_o;
    logic [KIDX_W-1:0]                    kidx_o;
    logic                                 valid_o;
    logic                                 sop_o;
    logic                                 eop_o;
    logic                                 sof_o;
    logic                                 eof_o;
    logic                                 busy_o;
    logic                                 err_o;

    modport master (
        output win_i, valid_i, sop_i, eop_i, sof_i, eof_i,
        input  ready_o,
        input  win_o, kidx_o, valid_o, sop_o, eop_o, sof_o, eof_o, busy_o, err_o
    );

    modport slave (
        input  win_i, valid_i, sop_i, eop_i, sof_i, eof_i,
        output ready_o,
        output win_o, kidx_o, valid_o, sop_o, eop_o, sof_o, eof_o, busy_o, err_o
    );

endinterface

// File: rtl/conv_sched_proto_chk.sv
// conv_sched_proto_chk: frame-marker protocol checker for accepted windows.
//   clk, reset_n : clock, asynchronous active-low reset
//   xfer         : a window is accepted this cycle
//   sof, eof     : frame markers of the offered window
//   err          : sticky error, set one cycle after an offending transfer
// An error is a start-of-frame while already inside a frame, or an
// end-of-frame while outside one. A window carrying both markers is a
// complete frame on its own and is never an error.
module conv_sched_proto_chk (
    input  logic clk,
    input  logic reset_n,
    input  logic xfer,
    input  logic sof,
    input  logic eof,
    output logic err
);

    logic in_frame;
    logic err_set;

    assign err_set = xfer && ((sof && !eof && in_frame) || (eof && !sof && !in_frame));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_frame <= 1'b0;
            err      <= 1'b0;
        end else begin
            if (xfer) begin
                if (eof) begin
                    in_frame <= 1'b0;
                end else if (sof) begin
                    in_frame <= 1'b1;
                end
            end
            if (err_set) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/conv_kernel_sched.sv
// conv_kernel_sched: holds one 3x3 window and replays it once per kernel so a
// single convolver can walk all KERNEL_NUM weight sets.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : conv_kernel_sched_if.slave (window in, replay out, busy/err)
// Optional build macro CONV_KERNEL_SCHED_PROTO_CHK_EN adds the frame-marker
// checker driving err_o; without it err_o is constant 0.
module conv_kernel_sched
    import conv_sched_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int KERNEL_NUM = 16,
    parameter int KIDX_W     = kidx_width(KERNEL_NUM)
) (
    input  logic               clk,
    input  logic               reset_n,
    conv_kernel_sched_if.slave bus
);

    localparam logic [KIDX_W-1:0] KIDX_LAST = KIDX_W'(KERNEL_NUM - 1);

    state_t                               state, state_n;
    logic [KIDX_W-1:0]                    kidx, kidx_n;
    logic                                 last, ready, xfer;
    logic                                 cap_eop, cap_eof;
    logic                                 sop_n, eop_n, sof_n, eof_n;
    logic                                 sop_q, eop_q, sof_q, eof_q;
    logic [WIN_ELEMS-1:0][DATA_WIDTH-1:0] win_q;

    // The last replay cycle doubles as the accept slot for the next window,
    // which is what makes back-to-back windows gapless.
    assign last  = (state == REPLAY) && (kidx == KIDX_LAST);
    assign ready = (state == IDLE) || last;
    assign xfer  = bus.valid_i && ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            kidx  <= '0;
        end else begin
            state <= state_n;
            kidx  <= kidx_n;
        end
    end

    always_comb begin
        state_n = state;
        kidx_n  = kidx;
        case (state)
            IDLE: begin
                if (xfer) begin
                    state_n = REPLAY;
                    kidx_n  = '0;
                end
            end
            REPLAY: begin
                if (!last) begin
                    kidx_n = kidx + KIDX_W'(1);
                end else begin
                    kidx_n = '0;
                    if (!xfer) begin
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                kidx_n  = '0;
            end
        endcase
    end

    // Start markers belong to kidx 0, which is only ever entered by a transfer,
    // so they come straight from the inputs. End markers land on the final
    // kernel: from the inputs when KERNEL_NUM is 1, else from the capture.
    always_comb begin
        sop_n = xfer && bus.sop_i;
        sof_n = xfer && bus.sof_i;
        eop_n = 1'b0;
        eof_n = 1'b0;
        if ((state_n == REPLAY) && (kidx_n == KIDX_LAST)) begin
            eop_n = xfer ? bus.eop_i : cap_eop;
            eof_n = xfer ? bus.eof_i : cap_eof;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            win_q   <= '0;
            cap_eop <= 1'b0;
            cap_eof <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
        end else begin
            if (xfer) begin
                win_q   <= bus.win_i;
                cap_eop <= bus.eop_i;
                cap_eof <= bus.eof_i;
            end
            sop_q <= sop_n;
            eop_q <= eop_n;
            sof_q <= sof_n;
            eof_q <= eof_n;
        end
    end

    assign bus.ready_o = ready;
    assign bus.win_o   = win_q;
    assign bus.kidx_o  = kidx;
    assign bus.valid_o = (state == REPLAY);
    assign bus.busy_o  = (state == REPLAY);
    assign bus.sop_o   = sop_q;
    assign bus.eop_o   = eop_q;
    assign bus.sof_o   = sof_q;
    assign bus.eof_o   = eof_q;

`ifdef CONV_KERNEL_SCHED_PROTO_CHK_EN
    logic err;

    conv_sched_proto_chk u_proto_chk (
        .clk     (clk),
        .reset_n (reset_n),
        .xfer    (xfer),
        .sof     (bus.sof_i),
        .eof     (bus.eof_i),
        .err     (err)
    );

    assign bus.err_o = err;
`else
    assign bus.err_o = 1'b0;
`endif

endmodule

// File: doc/conv_kernel_sched.md
CONV_KERNEL_SCHED -- requirements
Module: conv_kernel_sched

Interface
REQ-001 Parameter DATA_WIDTH, default 8, is the width of each signed window element.
REQ-002 Parameter KERNEL_NUM, default 16, is the number of kernels (output channels) applied per window; legal range is 1..256.
REQ-003 Parameter KIDX_W, default $clog2(KERNEL_NUM) with a minimum of 1, is the kernel index width.
REQ-004 clk  in  1  is the clock; all logic is rising-edge.
REQ-005 reset_n  in  1  is the asynchronous, active-low reset.
REQ-006 win_i  in  9 x DATA_WIDTH signed  is the 3x3 pixel window.
REQ-007 valid_i  in  1  qualifies win_i and the input flags.
REQ-008 ready_o  out  1  means the block can accept a window this cycle.
REQ-009 sop_i, eop_i, sof_i, eof_i  in  1 each  are the line and frame markers of the window.
REQ-010 win_o  out  9 x DATA_WIDTH signed  is the held window presented to the convolver.
REQ-011 kidx_o  out  KIDX_W  is the kernel index (weight ROM address) paired with win_o.
REQ-012 valid_o  out  1  qualifies win_o and kidx_o.
REQ-013 sop_o, eop_o, sof_o, eof_o  out  1 each  are the markers re-timed to the replay sequence.
REQ-014 busy_o  out  1  is high while a window is being replayed.
REQ-015 err_o  out  1  is a sticky protocol-error flag.

Function
REQ-016 A transfer occurs when valid_i and ready_o are both high on a rising edge; the downstream has no backpressure.
REQ-017 The FSM has two states, IDLE and REPLAY.
REQ-018 IDLE: ready_o=1 and valid_o=0; a transfer captures win_i and the flags, sets kidx_o=0, and moves to REPLAY.
REQ-019 REPLAY: valid_o=1 every cycle; kidx_o increments by 1 each cycle from 0 to KERNEL_NUM-1.
REQ-020 In REPLAY, ready_o=1 only in the cycle where kidx_o==KERNEL_NUM-1; elsewhere it is 0.
REQ-021 A transfer in the last replay cycle reloads the window, sets kidx_o=0 and stays in REPLAY, giving gapless back-to-back operation.
REQ-022 With no transfer in the last replay cycle, the FSM returns to IDLE.
REQ-023 Latency: the first valid_o for a window is asserted exactly 1 cycle after its transfer.
REQ-024 Each window produces exactly KERNEL_NUM valid_o cycles.
REQ-025 win_o stays constant for the whole replay of a window.
REQ-026 sop_o and sof_o equal the captured sop/sof while kidx_o==0, and are 0 otherwise.
REQ-027 eop_o and eof_o equal the captured eop/eof while kidx_o==KERNEL_NUM-1, and are 0 otherwise.
REQ-028 All flag outputs are 0 whenever valid_o=0.
REQ-029 For KERNEL_NUM=1, each window replays for one cycle, all four markers appear on that cycle, and ready_o stays high continuously.
REQ-030 busy_o=1 in REPLAY and 0 in IDLE.
REQ-031 All outputs are registered except ready_o, which is decoded from state and kidx_o.

Reset
REQ-032 Asserting reset_n forces IDLE, valid_o=0, kidx_o=0, win_o=0, all flag outputs 0, busy_o=0, err_o=0 and clears the in-frame tracker.
REQ-033 Reset mid-replay abandons the window with no further valid_o; ready_o=1 in the first cycle after release.

Configuration
REQ-034 Macro CONV_KERNEL_SCHED_PROTO_CHK_EN controls protocol checking.
REQ-035 With the macro defined, an in-frame bit sets on accepted sof_i and clears on accepted eof_i.
REQ-036 With the macro defined, err_o sets and holds until reset on either error: an accepted sof_i while in-frame (without eof_i in the same window), or an accepted eof_i while not in-frame (without sof_i in the same window).
REQ-037 Without the macro, err_o is tied to 0 and no checker logic is built.

Structure
REQ-038 Package conv_sched_pkg holds the state enum (IDLE, REPLAY), a window typedef (9 x DATA_WIDTH signed), and the KIDX_W helper function.
REQ-039 The checker is sub-module conv_sched_proto_chk, instantiated only under CONV_KERNEL_SCHED_PROTO_CHK_EN.

Verification
REQ-040 Single window with KERNEL_NUM=4 and sof_i=sop_i=1 -> valid_o high for 4 cycles starting 1 cycle after transfer; kidx_o 0,1,2,3; sof_o and sop_o only at kidx 0.
REQ-041 Continuous valid_i with KERNEL_NUM=4 -> valid_o never drops; ready_o high 1 cycle in 4; window N+1 appears at the cycle after kidx_o=3.
REQ-042 KERNEL_NUM=1 with 8 windows streamed -> 8 consecutive valid_o cycles with kidx_o=0; ready_o constant 1.
REQ-043 reset_n pulsed low at kidx_o=2 -> all outputs 0 immediately; after release ready_o=1 and the next window restarts at kidx_o=0.
REQ-044 Macro defined, sof_i accepted twice without eof_i -> err_o=1 one cycle after the second sof_i and held; macro undefined, same stimulus -> err_o=0.
